alu_pipe_acc: RTL and testbench

//  Parametrised, 2-stage pipelined successor to the flat combinational ALU benchmarks.

---
 rtl/alu_pipe_acc.sv | 151 +++++++++++++++
 tb/tb_alu_pipe_acc.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_acc.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_acc
// Description : Two-stage pipelined ALU (8 ops, Z/N/C/V flags) with an
//               internal accumulator and valid/ready handshakes on both sides.
//               Stage 1 captures the request; stage 2 holds the computed
//               result. One result per clock at full throughput.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe_acc #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_use_acc,
    input  logic             in_acc_wr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [3:0]       out_flags,
    output logic [WIDTH-1:0] acc
);

    localparam logic [2:0] C_OP_ADD  = 3'd0;
    localparam logic [2:0] C_OP_SUB  = 3'd1;
    localparam logic [2:0] C_OP_AND  = 3'd2;
    localparam logic [2:0] C_OP_OR   = 3'd3;
    localparam logic [2:0] C_OP_XOR  = 3'd4;
    localparam logic [2:0] C_OP_XNOR = 3'd5;
    localparam logic [2:0] C_OP_SHL  = 3'd6;
    localparam logic [2:0] C_OP_SHR  = 3'd7;

    // Stage 1: captured request
    logic             r_s1_v;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;
    logic             r_s1_use_acc;
    logic             r_s1_acc_wr;

    // Stage 2: result and accumulator
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_res;
    logic [3:0]       r_out_flags;
    logic [WIDTH-1:0] r_acc;

    logic             w_adv2;
    logic             w_accept;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c;
    logic             w_v;
    logic [3:0]       w_flags;

    // Stage 2 can take s1 when it is empty or being drained this cycle;
    // s1 can take a new request when empty or moving on.
    assign w_adv2   = r_s1_v & (~r_out_valid | out_ready);
    assign in_ready = ~r_s1_v | w_adv2;
    assign w_accept = in_valid & in_ready;

    assign out_valid = r_out_valid;
    assign out_res   = r_out_res;
    assign out_flags = r_out_flags;
    assign acc       = r_acc;

    // Stage 1 capture: a simultaneous accept and advance keeps s1 full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v       <= 1'b0;
            r_s1_op      <= 3'd0;
            r_s1_a       <= '0;
            r_s1_b       <= '0;
            r_s1_cin     <= 1'b0;
            r_s1_use_acc <= 1'b0;
            r_s1_acc_wr  <= 1'b0;
        end else if (w_accept) begin
            r_s1_v       <= 1'b1;
            r_s1_op      <= in_op;
            r_s1_a       <= in_a;
            r_s1_b       <= in_b;
            r_s1_cin     <= in_cin;
            r_s1_use_acc <= in_use_acc;
            r_s1_acc_wr  <= in_acc_wr;
        end else if (w_adv2) begin
            r_s1_v       <= 1'b0;
        end
    end

    // ALU datapath from s1; the accumulator is read live so chained ops see the latest write
    always_comb begin
        w_opa = r_s1_use_acc ? r_acc : r_s1_a;
        w_opb = (r_s1_op == C_OP_SUB) ? ~r_s1_b : r_s1_b;
        w_sum = {1'b0, w_opa} + {1'b0, w_opb} + {{WIDTH{1'b0}}, r_s1_cin};
        w_res = w_sum[WIDTH-1:0];
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (r_s1_op)
            C_OP_ADD, C_OP_SUB: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_opa[WIDTH-1] == w_opb[WIDTH-1]) &
                        (w_sum[WIDTH-1] != w_opa[WIDTH-1]);
            end
            C_OP_AND:  w_res = w_opa & r_s1_b;
            C_OP_OR:   w_res = w_opa | r_s1_b;
            C_OP_XOR:  w_res = w_opa ^ r_s1_b;
            C_OP_XNOR: w_res = ~(w_opa ^ r_s1_b);
            C_OP_SHL: begin
                w_res = {w_opa[WIDTH-2:0], 1'b0};
                w_c   = w_opa[WIDTH-1];
            end
            C_OP_SHR: begin
                w_res = {1'b0, w_opa[WIDTH-1:1]};
                w_c   = w_opa[0];
            end
            default: w_res = w_sum[WIDTH-1:0];
        endcase
        w_flags = {~|w_res, w_res[WIDTH-1], w_c, w_v};
    end

    // Stage 2 load / drain and accumulator write-back on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_res   <= '0;
            r_out_flags <= 4'd0;
            r_acc       <= ACC_INIT;
        end else if (w_adv2) begin
            r_out_valid <= 1'b1;
            r_out_res   <= w_res;
            r_out_flags <= w_flags;
            if (r_s1_acc_wr) begin
                r_acc <= w_res;
            end
        end else if (r_out_valid & out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_acc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe_acc
// Description : Bench for alu_pipe_acc. Three instances (WIDTH 2, 8, 16) share
//               one stimulus stream; a transaction-queue model predicts
//               handshakes, results, flags and accumulator contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  in_op = 3'd0;
    logic [15:0] in_a = 16'd0;
    logic [15:0] in_b = 16'd0;
    logic        in_cin = 1'b0;
    logic        in_use_acc = 1'b0;
    logic        in_acc_wr = 1'b0;

    always #5 clk = ~clk;

    logic        rdy2, rdy8, rdy16, ov2, ov8, ov16;
    logic [1:0]  res_w2, acc_w2;
    logic [7:0]  res_w8, acc_w8;
    logic [15:0] res_w16, acc_w16;
    logic [3:0]  flg2, flg8, flg16;

    alu_pipe_acc #(.WIDTH(2), .ACC_INIT(2'b01)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_op(in_op),
        .in_a(in_a[1:0]), .in_b(in_b[1:0]), .in_cin(in_cin), .in_use_acc(in_use_acc),
        .in_acc_wr(in_acc_wr), .out_valid(ov2), .out_ready(out_ready),
        .out_res(res_w2), .out_flags(flg2), .acc(acc_w2));

    alu_pipe_acc #(.WIDTH(8), .ACC_INIT(8'h00)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_op(in_op),
        .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_cin(in_cin), .in_use_acc(in_use_acc),
        .in_acc_wr(in_acc_wr), .out_valid(ov8), .out_ready(out_ready),
        .out_res(res_w8), .out_flags(flg8), .acc(acc_w8));

    alu_pipe_acc #(.WIDTH(16), .ACC_INIT(16'h1234)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_use_acc(in_use_acc),
        .in_acc_wr(in_acc_wr), .out_valid(ov16), .out_ready(out_ready),
        .out_res(res_w16), .out_flags(flg16), .acc(acc_w16));

    logic        d_rdy [3];
    logic        d_ov  [3];
    logic [15:0] d_res [3];
    logic [3:0]  d_flg [3];
    logic [15:0] d_acc [3];
    assign d_rdy[0] = rdy2;  assign d_rdy[1] = rdy8;  assign d_rdy[2] = rdy16;
    assign d_ov[0]  = ov2;   assign d_ov[1]  = ov8;   assign d_ov[2]  = ov16;
    assign d_res[0] = {14'd0, res_w2}; assign d_res[1] = {8'd0, res_w8}; assign d_res[2] = res_w16;
    assign d_flg[0] = flg2;  assign d_flg[1] = flg8;  assign d_flg[2] = flg16;
    assign d_acc[0] = {14'd0, acc_w2}; assign d_acc[1] = {8'd0, acc_w8}; assign d_acc[2] = acc_w16;

    function automatic int width_of(input int i);
        return (i == 0) ? 2 : (i == 1) ? 8 : 16;
    endfunction

    function automatic logic [15:0] init_of(input int i);
        return (i == 0) ? 16'h0001 : (i == 1) ? 16'h0000 : 16'h1234;
    endfunction

    // Reference ALU: plain integer arithmetic on unsigned/signed interpretations
    function automatic void ref_alu(input int w, input logic [2:0] op, input longint a_in,
                                    input longint b_in, input int cin,
                                    output longint r, output logic [3:0] f);
        longint m, half, a, b, sa, sb, x, s;
        logic   c, v;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        a    = a_in & m;
        b    = b_in & m;
        sa   = (a >= half) ? a - (m + 1) : a;
        sb   = (b >= half) ? b - (m + 1) : b;
        c    = 1'b0;
        v    = 1'b0;
        x    = 0;
        case (op)
            3'd0: begin x = a + b + cin;     c = (x > m);  s = sa + sb + cin;     v = (s >= half) || (s < -half); end
            3'd1: begin x = a - b + cin - 1; c = (x >= 0); s = sa - sb + cin - 1; v = (s >= half) || (s < -half); end
            3'd2: x = a & b;
            3'd3: x = a | b;
            3'd4: x = a ^ b;
            3'd5: x = ~(a ^ b);
            3'd6: begin x = a << 1; c = (a >= half); end
            default: begin x = a >> 1; c = ((a & 1) != 0); end
        endcase
        r = x & m;
        f = {r == 0, r >= half, c, v};
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        ua;
        logic        aw;
        int          cyc;
    } txn_t;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] er;
        logic [3:0] ef;
    } vec_t;

    txn_t        q[$];
    logic [15:0] macc [3];
    logic [15:0] held_res [3];
    logic [3:0]  held_flg [3];
    logic        hold_prev;
    int          cyc_idx, n_acc, acc_cyc, xfer_cyc;
    logic        acc_now, xfer_now;
    logic [15:0] xlog_res[$];
    int          xlog_cyc[$];
    int          n_vec, n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_idx);
        end
    endtask

    // One clock: check handshakes/outputs at negedge, track accepts and transfers
    task automatic cycle();
        txn_t       t, h;
        longint     r;
        logic [3:0] f;
        logic       exp_rdy, exp_ov;
        @(negedge clk);
        exp_rdy = (q.size() < 2) || out_ready;
        exp_ov  = (q.size() > 0) && (q[0].cyc <= cyc_idx - 2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("in_ready_w%0d", width_of(i)), {31'd0, d_rdy[i]}, {31'd0, exp_rdy});
            chk($sformatf("out_valid_w%0d", width_of(i)), {31'd0, d_ov[i]}, {31'd0, exp_ov});
            if (hold_prev) begin
                chk($sformatf("hold_res_w%0d", width_of(i)), {16'd0, d_res[i]}, {16'd0, held_res[i]});
                chk($sformatf("hold_flags_w%0d", width_of(i)), {28'd0, d_flg[i]}, {28'd0, held_flg[i]});
            end
        end
        xfer_now = ov8 & out_ready;
        acc_now  = in_valid & rdy8;
        if (xfer_now) begin
            if (q.size() == 0) begin
                chk("spurious_output", 32'd1, 32'd0);
            end else begin
                h = q.pop_front();
                for (int i = 0; i < 3; i++) begin
                    ref_alu(width_of(i), h.op, longint'(h.ua ? macc[i] : h.a), longint'(h.b),
                            int'(h.cin), r, f);
                    if (h.aw) macc[i] = r[15:0];
                    chk($sformatf("res_w%0d", width_of(i)), {16'd0, d_res[i]}, r[31:0]);
                    chk($sformatf("flags_w%0d", width_of(i)), {28'd0, d_flg[i]}, {28'd0, f});
                    chk($sformatf("acc_w%0d", width_of(i)), {16'd0, d_acc[i]}, {16'd0, macc[i]});
                end
            end
            xlog_res.push_back({8'd0, res_w8});
            xlog_cyc.push_back(cyc_idx);
            xfer_cyc = cyc_idx;
        end
        hold_prev = ov8 & ~out_ready;
        for (int i = 0; i < 3; i++) begin
            held_res[i] = d_res[i];
            held_flg[i] = d_flg[i];
        end
        if (acc_now) begin
            t.op = in_op; t.a = in_a; t.b = in_b; t.cin = in_cin;
            t.ua = in_use_acc; t.aw = in_acc_wr; t.cyc = cyc_idx;
            q.push_back(t);
            n_acc++;
            acc_cyc = cyc_idx;
        end
        @(posedge clk);
        #1;
        cyc_idx++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc_idx += 4;
        q.delete();
        hold_prev = 1'b0;
        xlog_res.delete();
        xlog_cyc.delete();
        for (int i = 0; i < 3; i++) begin
            macc[i] = init_of(i);
            chk($sformatf("rst_out_valid_w%0d", width_of(i)), {31'd0, d_ov[i]}, 32'd0);
            chk($sformatf("rst_in_ready_w%0d", width_of(i)), {31'd0, d_rdy[i]}, 32'd1);
            chk($sformatf("rst_res_w%0d", width_of(i)), {16'd0, d_res[i]}, 32'd0);
            chk($sformatf("rst_flags_w%0d", width_of(i)), {28'd0, d_flg[i]}, 32'd0);
            chk($sformatf("rst_acc_w%0d", width_of(i)), {16'd0, d_acc[i]}, {16'd0, init_of(i)});
        end
    endtask

    task automatic issue_one(input vec_t v, input int idx);
        logic got;
        in_op = v.op; in_a = {8'h5A, v.a}; in_b = {8'hC3, v.b}; in_cin = v.cin;
        in_use_acc = 1'b0; in_acc_wr = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        acc_now = 1'b0;
        for (int k = 0; k < 10 && !acc_now; k++) cycle();
        in_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle();
            if (xfer_now) got = 1'b1;
        end
        chk($sformatf("vec%0d_done", idx), {31'd0, got}, 32'd1);
        chk($sformatf("vec%0d_res", idx), {24'd0, xlog_res[xlog_res.size()-1][7:0]}, {24'd0, v.er});
        chk($sformatf("vec%0d_latency", idx), xfer_cyc - acc_cyc, 32'd2);
        chk($sformatf("vec%0d_flags", idx), {28'd0, flg8}, {28'd0, v.ef});
    endtask

    initial begin
        vec_t tv[12];
        int   v;
        n_vec = 0; n_err = 0; cyc_idx = 0; n_acc = 0; acc_cyc = 0; xfer_cyc = 0;
        hold_prev = 1'b0; acc_now = 1'b0; xfer_now = 1'b0;
        //        op    a      b      cin   res    {Z,N,C,V}
        tv[0]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1010};
        tv[1]  = '{3'd1, 8'h80, 8'h01, 1'b1, 8'h7F, 4'b0011};
        tv[2]  = '{3'd2, 8'hA5, 8'h3C, 1'b0, 8'h24, 4'b0000};
        tv[3]  = '{3'd3, 8'hA5, 8'h3C, 1'b0, 8'hBD, 4'b0100};
        tv[4]  = '{3'd4, 8'hA5, 8'h3C, 1'b0, 8'h99, 4'b0100};
        tv[5]  = '{3'd5, 8'hA5, 8'h3C, 1'b0, 8'h66, 4'b0000};
        tv[6]  = '{3'd6, 8'hA5, 8'h3C, 1'b0, 8'h4A, 4'b0010};
        tv[7]  = '{3'd7, 8'hA5, 8'h3C, 1'b0, 8'h52, 4'b0010};
        tv[8]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101};
        tv[9]  = '{3'd1, 8'h05, 8'h05, 1'b1, 8'h00, 4'b1010};
        tv[10] = '{3'd1, 8'h00, 8'h01, 1'b1, 8'hFF, 4'b0100};
        tv[11] = '{3'd0, 8'h10, 8'h20, 1'b1, 8'h31, 4'b0000};

        do_reset();
        for (int i = 0; i < 12; i++) issue_one(tv[i], i);

        // Accumulator chain: four back-to-back ADD +1 through acc
        do_reset();
        in_op = 3'd0; in_a = 16'hBEEF; in_b = 16'd1; in_cin = 1'b0;
        in_use_acc = 1'b1; in_acc_wr = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        chk("chain_count", xlog_res.size(), 32'd4);
        if (xlog_res.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("chain_res%0d", k), {16'd0, xlog_res[k]}, k + 1);
                if (k > 0) chk($sformatf("chain_gap%0d", k), xlog_cyc[k] - xlog_cyc[k-1], 32'd1);
            end
        end
        chk("chain_acc", {24'd0, acc_w8}, 32'd4);

        // Backpressure: sink stalls for 5 cycles while the source streams
        do_reset();
        in_op = 3'd0; in_b = 16'd0; in_cin = 1'b0; in_use_acc = 1'b0; in_acc_wr = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; v = 1; n_acc = 0;
        for (int k = 0; k < 5; k++) begin
            in_a = 16'(v);
            cycle();
            if (acc_now) v++;
        end
        chk("bp_accepts_while_stalled", n_acc, 32'd2);
        out_ready = 1'b1;
        for (int k = 0; k < 20 && v <= 6; k++) begin
            in_a = 16'(v);
            cycle();
            if (acc_now) v++;
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        chk("bp_count", xlog_res.size(), 32'd6);
        if (xlog_res.size() == 6)
            for (int k = 0; k < 6; k++) chk($sformatf("bp_order%0d", k), {16'd0, xlog_res[k]}, k + 1);
        chk("bp_drained", q.size(), 32'd0);

        // Reset with both stages full: nothing may emerge afterwards
        do_reset();
        in_op = 3'd0; in_a = 16'h0055; in_b = 16'h0000; in_use_acc = 1'b0; in_acc_wr = 1'b1;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        chk("full_before_reset", q.size(), 32'd2);
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) cycle();
        chk("no_output_after_reset", xlog_res.size(), 32'd0);

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 14000; k++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 7);
            in_op      = 3'($urandom_range(0, 7));
            in_a       = 16'($urandom);
            in_b       = 16'($urandom);
            in_cin     = 1'($urandom);
            in_use_acc = 1'($urandom);
            in_acc_wr  = 1'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        chk("random_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
